iq_slot_alloc8: RTL and testbench
=================================

# iq_slot_alloc8

Slot allocator and occupancy tracker for one 8-entry issue queue. It sits directly downstream of `empty_entry_finder8_wrapper`. Each cycle it registers the finder's two allocatable slot indices, grants up to two in-order dispatch requests into those slots, and owns the per-slot valid bitmap. Slots are freed on issue or flush. The bitmap and the granted dispatch indices feed back into the finder as `slot_valid` and `dispatch_slot_idx0/1`.

## Interface
- `NUM_SLOTS`, 8, number of queue slots; only 8 is supported, to match the 8-entry finder.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `find_idx0`, `find_idx1`  in  3  allocatable slot indices from the finder (combinational, current cycle).
- `find_idx0_valid`, `find_idx1_valid`  in  1  finder index valids.
- `dispatch_req0`, `dispatch_req1`  in  1  dispatch requests; `dispatch_req1` is legal only with `dispatch_req0`.
- `dispatch_gnt0`, `dispatch_gnt1`  out  1  combinational grants.
- `dispatch_slot_idx0`, `dispatch_slot_idx1`  out  3  granted slot indices (registered allocatable indices).
- `dispatch_slot_idx0_valid`, `dispatch_slot_idx1_valid`  out  1  equal to `dispatch_gnt0` and `dispatch_gnt1`.
- `issue_valid0`, `issue_valid1`  in  1  slot-free requests from the select logic.
- `issue_idx0`, `issue_idx1`  in  3  slots to free.
- `flush`  in  1  clears the whole queue.
- `slot_valid[8]`  out  1 each  registered occupancy bitmap.
- `occupancy`  out  4  registered count of valid slots, 0..8.
- `queue_full`  out  1  `occupancy == 8`.
- `alloc_err`  out  1  sticky consistency error (see Configuration).

## Operation
- Allocation register: each cycle, `alloc_idx_q0/1` ← `find_idx0/1` and `alloc_vld_q0/1` ← `find_idx0/1_valid`. On `flush`, `alloc_vld_q0/1` ← 0.
- Grant logic:
  - `dispatch_gnt0 = dispatch_req0 & alloc_vld_q0 & ~flush`.
  - `dispatch_gnt1 = dispatch_req1 & dispatch_gnt0 & alloc_vld_q1 & ~flush`.
  - Partial grant is legal: req0 is granted and req1 is refused when only q0 is valid. Upstream holds the refused instruction.
  - `dispatch_slot_idxN = alloc_idx_qN`.
- Bitmap update, no flush: `slot_valid[i]` next = (`slot_valid[i]` & ~issued(i)) | dispatched(i).
  - `issued(i)`: `issue_validN` with `issue_idxN == i`, for N = 0 or 1.
  - `dispatched(i)`: `dispatch_gntN` with `dispatch_slot_idxN == i`.
  - Dispatch wins over issue on the same slot; this is only reachable on illegal stimulus, which is flagged as an error.
- Flush: all `slot_valid` ← 0 and `occupancy` ← 0. Dispatch and issue in the same cycle are discarded.
- Occupancy: `occupancy` next = `occupancy` + grants − effective frees. An effective free is an issue to a currently valid slot; duplicate indices count once. The count is always equal to popcount(`slot_valid`).
- Issue to an empty slot has no state effect.

## Timing
- Reset values: `slot_valid` all 0, `occupancy` 0, `queue_full` 0, `alloc_vld_q0/1` 0, `alloc_idx_q0/1` 0, `alloc_err` 0. Grants are 0 while reset is asserted.
- First cycle after reset deassertion: no grant, because the allocation register is still invalid. From the second cycle, q0=0 and q1=1 are valid.
- Dispatch latency: a slot granted in cycle N shows `slot_valid` = 1 in N+1. The finder excludes it in cycle N through `dispatch_slot_idx*`, so the q registers in N+1 never repeat it.
- Free latency: a slot issued in cycle N clears in N+1. It is allocatable by the finder in N+1 and grantable from N+2.
- Flush latency: bitmap is clear in N+1; no grants in N or N+1; grants resume in N+2.
- Full: `queue_full` = 1 leads to finder valids of 0 and therefore no grants. A simultaneous issue and dispatch request leaves the queue at 7 and grants nothing that cycle.
- Asynchronous reset mid-operation drops all in-flight grants immediately.

## Configuration
- `IQ_SLOT_CHECK_EN` defined:
  - `alloc_err` is set (sticky until `rst`) on any of:
    - a grant to a slot that is already valid;
    - issue to an empty slot;
    - `dispatch_req1` without `dispatch_req0`;
    - both grants to the same slot.
  - Simulation `$error` is raised on the same conditions.
- `IQ_SLOT_CHECK_EN` undefined: `alloc_err` is tied to 0 and no check logic is generated.

## Test plan
- Reset, then two requests every cycle with no issue → cycles 2..5 grant pairs (0,1), (2,3), (4,5), (6,7); `occupancy` reaches 8 and `queue_full`=1; further requests get no grant.
- Full queue, issue slot 3 in cycle N with req0 held → `slot_valid[3]`=0 in N+1; grant with `dispatch_slot_idx0`=3 in N+2; `occupancy` back to 8.
- Slots 0–6 valid, req0+req1 → `dispatch_gnt0`=1 with idx 7 and `dispatch_gnt1`=0; `occupancy`=8 next cycle.
- Flush concurrent with a req0/req1 grant opportunity and issue of slot 2 → grants 0; next cycle all `slot_valid`=0 and `occupancy`=0; grants resume two cycles later with idx 0 and 1.
- Same-cycle issue of slots 4 and 5 plus dispatch into slots 1 and 6 → `occupancy` unchanged; bitmap updated exactly.
- With `IQ_SLOT_CHECK_EN`: issue slot 5 while it is empty → `alloc_err`=1, held until `rst`. Without the macro → `alloc_err` stays 0.

Source files
------------

// File: rtl/iq_slot_alloc8.sv
// iq_slot_alloc8 -- slot allocator and occupancy tracker for an 8-entry issue queue.
//
// Registers the two allocatable slot indices offered by the empty-entry finder,
// grants up to two in-order dispatch requests into them, and owns the per-slot
// valid bitmap and occupancy count. Slots are freed by issue or by flush.
//
// Optional feature macro: IQ_SLOT_CHECK_EN
//   defined   -> sticky alloc_err plus simulation $error on inconsistent traffic
//   undefined -> alloc_err tied to 0, no check logic
module iq_slot_alloc8 #(
  // Only 8 is supported; the upstream finder is fixed at 8 entries.
  parameter int NUM_SLOTS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           find_idx0,
  input  logic [2:0]           find_idx1,
  input  logic                 find_idx0_valid,
  input  logic                 find_idx1_valid,
  input  logic                 dispatch_req0,
  input  logic                 dispatch_req1,
  output logic                 dispatch_gnt0,
  output logic                 dispatch_gnt1,
  output logic [2:0]           dispatch_slot_idx0,
  output logic [2:0]           dispatch_slot_idx1,
  output logic                 dispatch_slot_idx0_valid,
  output logic                 dispatch_slot_idx1_valid,
  input  logic                 issue_valid0,
  input  logic                 issue_valid1,
  input  logic [2:0]           issue_idx0,
  input  logic [2:0]           issue_idx1,
  input  logic                 flush,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [3:0]           occupancy,
  output logic                 queue_full,
  output logic                 alloc_err
);

  // Allocation register: the finder's picks from the previous cycle.
  logic [2:0]           alloc_idx_q0, alloc_idx_d0;
  logic [2:0]           alloc_idx_q1, alloc_idx_d1;
  logic                 alloc_vld_q0, alloc_vld_d0;
  logic                 alloc_vld_q1, alloc_vld_d1;

  // Occupancy state.
  logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [3:0]           occupancy_q, occupancy_d;

  // Per-cycle one-hot views of issue and dispatch traffic.
  logic [NUM_SLOTS-1:0] issue_mask;
  logic [NUM_SLOTS-1:0] dispatch_mask;
  logic [NUM_SLOTS-1:0] added_mask;
  logic [NUM_SLOTS-1:0] removed_mask;

  function automatic logic [3:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  // Grants: in-order, slot 1 only behind slot 0, nothing during flush.
  assign dispatch_gnt0 = dispatch_req0 & alloc_vld_q0 & ~flush;
  assign dispatch_gnt1 = dispatch_req1 & dispatch_gnt0 & alloc_vld_q1 & ~flush;

  assign dispatch_slot_idx0       = alloc_idx_q0;
  assign dispatch_slot_idx1       = alloc_idx_q1;
  assign dispatch_slot_idx0_valid = dispatch_gnt0;
  assign dispatch_slot_idx1_valid = dispatch_gnt1;

  assign slot_valid = slot_valid_q;
  assign occupancy  = occupancy_q;
  assign queue_full = (occupancy_q == 4'd8);

  // Next allocation register: always follow the finder, invalidate on flush.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    alloc_idx_d0 = find_idx0;
    alloc_idx_d1 = find_idx1;
    alloc_vld_d0 = find_idx0_valid;
    alloc_vld_d1 = find_idx1_valid;
    if (flush) begin
      alloc_vld_d0 = 1'b0;
      alloc_vld_d1 = 1'b0;
    end
  end

  // Decode issue and dispatch indices into slot masks.
  always_comb begin
    issue_mask    = ({{(NUM_SLOTS-1){1'b0}}, issue_valid0} << issue_idx0)
                  | ({{(NUM_SLOTS-1){1'b0}}, issue_valid1} << issue_idx1);
    dispatch_mask = ({{(NUM_SLOTS-1){1'b0}}, dispatch_gnt0} << alloc_idx_q0)
                  | ({{(NUM_SLOTS-1){1'b0}}, dispatch_gnt1} << alloc_idx_q1);
  end

  // Next bitmap and occupancy; flush clears everything and drops same-cycle traffic.
  always_comb begin
    slot_valid_d = (slot_valid_q & ~issue_mask) | dispatch_mask;
    // Count exactly the bits that turn on and off, so the counter tracks the
    // bitmap's popcount even when a dispatch collides with an issue or a
    // dispatch targets an already valid slot. On legal traffic these are
    // simply the grants and the effective (deduplicated) frees.
    added_mask   = dispatch_mask & ~slot_valid_q;
    removed_mask = slot_valid_q & issue_mask & ~dispatch_mask;
    occupancy_d  = occupancy_q + popcount(added_mask) - popcount(removed_mask);
    if (flush) begin
      slot_valid_d = '0;
      occupancy_d  = 4'd0;
    end
  end

  // State registers with asynchronous reset; reset empties the queue at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bitmap is control state, not a data array, so it must be reset.
      alloc_idx_q0 <= 3'd0;
      alloc_idx_q1 <= 3'd0;
      alloc_vld_q0 <= 1'b0;
      alloc_vld_q1 <= 1'b0;
      slot_valid_q <= '0;
      occupancy_q  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      alloc_idx_q0 <= alloc_idx_d0;
      alloc_idx_q1 <= alloc_idx_d1;
      alloc_vld_q0 <= alloc_vld_d0;
      alloc_vld_q1 <= alloc_vld_d1;
      slot_valid_q <= slot_valid_d;
      occupancy_q  <= occupancy_d;
    end
  end

`ifdef IQ_SLOT_CHECK_EN
  logic err_dup_alloc;
  logic err_issue_empty;
  logic err_req_order;
  logic err_same_slot;
  logic err_now;
  logic alloc_err_q, alloc_err_d;

  // Detect inconsistent traffic; issue during flush is discarded, so not checked.
  always_comb begin
    err_dup_alloc   = (dispatch_gnt0 & slot_valid_q[alloc_idx_q0])
                    | (dispatch_gnt1 & slot_valid_q[alloc_idx_q1]);
    err_issue_empty = ~flush & ((issue_valid0 & ~slot_valid_q[issue_idx0])
                              | (issue_valid1 & ~slot_valid_q[issue_idx1]));
    err_req_order   = dispatch_req1 & ~dispatch_req0;
    err_same_slot   = dispatch_gnt0 & dispatch_gnt1 & (alloc_idx_q0 == alloc_idx_q1);
    err_now         = err_dup_alloc | err_issue_empty | err_req_order | err_same_slot;
    alloc_err_d     = alloc_err_q | err_now;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_err_q <= 1'b0;
    end else begin
      alloc_err_q <= alloc_err_d;
      if (err_now) begin
        $error("iq_slot_alloc8: dup_alloc=%0b issue_empty=%0b req_order=%0b same_slot=%0b",
               err_dup_alloc, err_issue_empty, err_req_order, err_same_slot);
      end
    end
  end

  assign alloc_err = alloc_err_q;
`else
  assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_iq_slot_alloc8.sv
// tb_iq_slot_alloc8 -- scoreboard bench for iq_slot_alloc8.
// The bench also plays the empty-entry finder: each cycle it offers the two
// lowest slots that are neither occupied nor being granted this cycle.
module tb_iq_slot_alloc8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] find_idx0, find_idx1;
  logic       find_idx0_valid, find_idx1_valid;
  logic       dispatch_req0, dispatch_req1;
  logic       dispatch_gnt0, dispatch_gnt1;
  logic [2:0] dispatch_slot_idx0, dispatch_slot_idx1;
  logic       dispatch_slot_idx0_valid, dispatch_slot_idx1_valid;
  logic       issue_valid0, issue_valid1;
  logic [2:0] issue_idx0, issue_idx1;
  logic       flush;
  logic [7:0] slot_valid;
  logic [3:0] occupancy;
  logic       queue_full;
  logic       alloc_err;

  iq_slot_alloc8 dut (
    .clk                      (clk),
    .rst                      (rst),
    .find_idx0                (find_idx0),
    .find_idx1                (find_idx1),
    .find_idx0_valid          (find_idx0_valid),
    .find_idx1_valid          (find_idx1_valid),
    .dispatch_req0            (dispatch_req0),
    .dispatch_req1            (dispatch_req1),
    .dispatch_gnt0            (dispatch_gnt0),
    .dispatch_gnt1            (dispatch_gnt1),
    .dispatch_slot_idx0       (dispatch_slot_idx0),
    .dispatch_slot_idx1       (dispatch_slot_idx1),
    .dispatch_slot_idx0_valid (dispatch_slot_idx0_valid),
    .dispatch_slot_idx1_valid (dispatch_slot_idx1_valid),
    .issue_valid0             (issue_valid0),
    .issue_valid1             (issue_valid1),
    .issue_idx0               (issue_idx0),
    .issue_idx1               (issue_idx1),
    .flush                    (flush),
    .slot_valid               (slot_valid),
    .occupancy                (occupancy),
    .queue_full               (queue_full),
    .alloc_err                (alloc_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected view of the DUT during one cycle.
  typedef struct {
    bit       g0, g1;
    bit [2:0] i0, i1;
    bit [7:0] sv;
    int       occ;
    bit       full;
    bit       err;
  } exp_t;

  exp_t sbq[$];

  // Reference model: occupied set, last cycle's finder offer, sticky error.
  bit occ_m[8];
  bit mq_vld[2];
  int mq_idx[2];
  bit err_m;

  task automatic model_reset();
    foreach (occ_m[i]) occ_m[i] = 1'b0;
    mq_vld[0] = 1'b0; mq_vld[1] = 1'b0;
    mq_idx[0] = 0;    mq_idx[1] = 0;
    err_m = 1'b0;
  endtask

  // One cycle: drive inputs, push expectation, advance model, move to next cycle.
  task automatic step(input bit r0, input bit r1, input bit iv0, input int i0,
                      input bit iv1, input int i1, input bit fl);
    exp_t e;
    int   free_list[$];
    int   cnt;
    bit   g0, g1;
    g0 = r0 && mq_vld[0] && !fl;
    g1 = r1 && g0 && mq_vld[1] && !fl;
    for (int s = 0; s < 8; s++) begin
      if (!occ_m[s] && !(g0 && mq_idx[0] == s) && !(g1 && mq_idx[1] == s))
        free_list.push_back(s);
    end
    dispatch_req0   = r0;
    dispatch_req1   = r1;
    issue_valid0    = iv0;
    issue_idx0      = 3'(i0);
    issue_valid1    = iv1;
    issue_idx1      = 3'(i1);
    flush           = fl;
    find_idx0_valid = free_list.size() > 0;
    find_idx1_valid = free_list.size() > 1;
    find_idx0       = (free_list.size() > 0) ? 3'(free_list[0]) : 3'd0;
    find_idx1       = (free_list.size() > 1) ? 3'(free_list[1]) : 3'd0;

    cnt = 0;
    for (int s = 0; s < 8; s++) begin
      e.sv[s] = occ_m[s];
      if (occ_m[s]) cnt++;
    end
    e.g0   = g0;
    e.g1   = g1;
    e.i0   = 3'(mq_idx[0]);
    e.i1   = 3'(mq_idx[1]);
    e.occ  = cnt;
    e.full = (cnt == 8);
    e.err  = err_m;
    sbq.push_back(e);

`ifdef IQ_SLOT_CHECK_EN
    if ((g0 && occ_m[mq_idx[0]]) || (g1 && occ_m[mq_idx[1]]) ||
        (!fl && ((iv0 && !occ_m[i0]) || (iv1 && !occ_m[i1]))) ||
        (r1 && !r0) || (g0 && g1 && mq_idx[0] == mq_idx[1]))
      err_m = 1'b1;
`endif

    if (fl) begin
      foreach (occ_m[s]) occ_m[s] = 1'b0;
      mq_vld[0] = 1'b0;
      mq_vld[1] = 1'b0;
    end else begin
      if (iv0) occ_m[i0] = 1'b0;
      if (iv1) occ_m[i1] = 1'b0;
      if (g0) occ_m[mq_idx[0]] = 1'b1;
      if (g1) occ_m[mq_idx[1]] = 1'b1;
      mq_vld[0] = free_list.size() > 0;
      mq_vld[1] = free_list.size() > 1;
    end
    mq_idx[0] = (free_list.size() > 0) ? free_list[0] : 0;
    mq_idx[1] = (free_list.size() > 1) ? free_list[1] : 0;

    @(posedge clk);
    #2;
  endtask

  // Monitor: mid-cycle, compare whatever the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("gnt0", dispatch_gnt0, e.g0);
        check("gnt1", dispatch_gnt1, e.g1);
        check("idx0_valid", dispatch_slot_idx0_valid, e.g0);
        check("idx1_valid", dispatch_slot_idx1_valid, e.g1);
        if (e.g0) check("idx0", dispatch_slot_idx0, e.i0);
        if (e.g1) check("idx1", dispatch_slot_idx1, e.i1);
        check("slot_valid", slot_valid, e.sv);
        check("occupancy", occupancy, e.occ);
        check("queue_full", queue_full, e.full);
        check("alloc_err", alloc_err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int occ_list[$];
    bit r0, r1, iv0, iv1, fl;
    int i0, i1;

    model_reset();
    rst             = 1'b1;
    dispatch_req0   = 1'b1;
    dispatch_req1   = 1'b1;
    issue_valid0    = 1'b0;
    issue_valid1    = 1'b0;
    issue_idx0      = 3'd0;
    issue_idx1      = 3'd0;
    flush           = 1'b0;
    find_idx0       = 3'd0;
    find_idx1       = 3'd1;
    find_idx0_valid = 1'b1;
    find_idx1_valid = 1'b1;

    // Reset state, with requests and finder valids active.
    #12;
    check("rst_gnt0", dispatch_gnt0, 0);
    check("rst_gnt1", dispatch_gnt1, 0);
    check("rst_slot_valid", slot_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_queue_full", queue_full, 0);
    check("rst_alloc_err", alloc_err, 0);
    check("rst_idx0", dispatch_slot_idx0, 0);
    check("rst_idx1", dispatch_slot_idx1, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Fill: grant pairs (0,1) (2,3) (4,5) (6,7) in cycles 2..5, then nothing.
    repeat (7) step(1, 1, 0, 0, 0, 0, 0);
    check("full_after_fill", queue_full, 1);
    check("occ_after_fill", occupancy, 8);

    // Full queue, issue slot 3 with req0 held; regrant into slot 3 two cycles later.
    step(1, 0, 1, 3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Slots 0..6 valid, pair request: partial grant into slot 7.
    step(0, 0, 1, 7, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Flush against a live grant opportunity and an issue of slot 2.
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 2, 0, 0, 1);
    repeat (7) step(1, 1, 0, 0, 0, 0, 0);

    // Issue 4 and 5 while dispatching into 1 and 6 in the same cycle.
    step(0, 0, 1, 1, 1, 6, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 4, 1, 5, 0);
    check("swap_slot_valid", slot_valid, 8'hCF);
    check("swap_occupancy", occupancy, 6);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; issues target occupied slots, duplicates allowed.
    repeat (400) begin
      occ_list.delete();
      foreach (occ_m[s]) if (occ_m[s]) occ_list.push_back(s);
      r0 = ($urandom_range(0, 3) != 0);
      r1 = r0 && ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 24) == 0);
      iv0 = 1'b0; iv1 = 1'b0; i0 = 0; i1 = 0;
      if (occ_list.size() > 0) begin
        iv0 = ($urandom_range(0, 1) == 1);
        iv1 = ($urandom_range(0, 2) == 0);
        i0  = occ_list[$urandom_range(0, occ_list.size() - 1)];
        i1  = occ_list[$urandom_range(0, occ_list.size() - 1)];
      end
      step(r0, r1, iv0, i0, iv1, i1, fl);
    end

    // Empty the queue, then issue slot 5 while it is empty.
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Grant 0 and 1, then assert reset mid-cycle with a grant in flight.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    dispatch_req0 = 1'b1;
    dispatch_req1 = 1'b1;
    #1;
    check("pre_rst_gnt0", dispatch_gnt0, 1);
    check("pre_rst_occupancy", occupancy, 2);
    rst = 1'b1;
    #1;
    check("async_rst_gnt0", dispatch_gnt0, 0);
    check("async_rst_gnt1", dispatch_gnt1, 0);
    check("async_rst_slot_valid", slot_valid, 0);
    check("async_rst_occupancy", occupancy, 0);
    check("async_rst_alloc_err", alloc_err, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (4) step(1, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
